comparador_serial_der_a_izq: RTL

- Sequential, bit-serial magnitude comparator. Processes two N-bit operands least-significant bit first (right to left), one bit per clock.
- It is the counterpart to the combinational left-to-right iterative cell chain. It reuses the same mode inputs `y`/`z` and the same per-bit relation semantics.
- It sits beside the parallel comparator wherever area matters more than latency.
- A start/done handshake frames each comparison. The result `f` is held until the next comparison completes.

---
 rtl/comparador_pkg.sv | 23 ++
 rtl/celda_der_a_izq.sv | 22 ++
 rtl/comparador_serial_der_a_izq.sv | 109 ++++++++++
 3 files changed

// File: rtl/comparador_pkg.sv
// Shared encodings for the serial right-to-left magnitude comparator.
package comparador_pkg;

  // Mode encodings for {y,z}; 2'b00 is reserved and always yields f = 0
  localparam logic [1:0] MODE_GT = 2'b01;
  localparam logic [1:0] MODE_LT = 2'b10;
  localparam logic [1:0] MODE_EQ = 2'b11;

  // Running relation between the bits of A and B examined so far
  typedef enum logic [1:0] {
    REL_EQ = 2'b00,
    REL_GT = 2'b01,
    REL_LT = 2'b10
  } rel_t;

  // Handshake FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/celda_der_a_izq.sv
// One right-to-left comparison cell: a differing bit replaces the relation
// accumulated from the less significant bits, equal bits pass it through.
module celda_der_a_izq
  import comparador_pkg::*;
(
  input  logic a_bit,
  input  logic b_bit,
  input  rel_t rel_in,
  output rel_t rel_out
);

  // Relation update for the current bit
  always_comb begin
    rel_out = rel_in;
    if (a_bit && !b_bit) begin
      rel_out = REL_GT;
    end else if (!a_bit && b_bit) begin
      rel_out = REL_LT;
    end
  end

endmodule

// File: rtl/comparador_serial_der_a_izq.sv
// Bit-serial magnitude comparator, LSB first, one bit per clock, with a
// start/busy/done handshake. f holds the last result until the next done.
module comparador_serial_der_a_izq
  import comparador_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         y,
  input  logic         z,
  output logic         busy,
  output logic         done,
  output logic         f
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  state_t         state;
  state_t         state_next;
  logic [CW-1:0]  cnt;
  rel_t           rel;
  rel_t           rel_step;
  logic [N-1:0]   a_sh;
  logic [N-1:0]   b_sh;
  logic [1:0]     mode_sh;
  logic           accept;
  logic           last_bit;

  // Final predicate from mode and relation; reserved mode gives 0
  function automatic logic pred(input logic [1:0] mode, input rel_t r);
    case (mode)
      MODE_GT: pred = (r == REL_GT);
      MODE_LT: pred = (r == REL_LT);
      MODE_EQ: pred = (r == REL_EQ);
      default: pred = 1'b0;
    endcase
  endfunction

  assign accept   = start && ((state == S_IDLE) || (state == S_DONE));
  assign last_bit = (cnt == CW'(N - 1));

  celda_der_a_izq u_celda (
    .a_bit   (a_sh[cnt]),
    .b_bit   (b_sh[cnt]),
    .rel_in  (rel),
    .rel_out (rel_step)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; start is only honoured in IDLE and DONE
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  state_next = start ? S_RUN : S_IDLE;
      S_RUN:   state_next = last_bit ? S_DONE : S_RUN;
      S_DONE:  state_next = start ? S_RUN : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Operand capture, bit counter, relation accumulation and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      mode_sh <= '0;
      cnt     <= '0;
      rel     <= REL_EQ;
      f       <= 1'b0;
    end else if (accept) begin
      a_sh    <= A;
      b_sh    <= B;
      mode_sh <= {y, z};
      cnt     <= '0;
      rel     <= REL_EQ;
    end else if (state == S_RUN) begin
      rel <= rel_step;
      // counter parks at 0 on the last bit so it never wraps past N-1
      cnt <= last_bit ? '0 : cnt + 1'b1;
      if (last_bit) begin
        f <= pred(mode_sh, rel_step);
      end
    end
  end

endmodule
